exec_sequencer: RTL and testbench

EXEC_SEQUENCER -- requirements
Module: exec_sequencer

---
 rtl/exec_sequencer_pkg.sv | 46 ++++
 rtl/exec_sequencer.sv | 155 +++++++++++++++
 tb/tb_exec_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_pkg.sv
// rtl/exec_sequencer_pkg.sv - shared cpu package: sequencer states, opcode constants, NOP, legality check.
package exec_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam int NUM_LEGAL_OPS = 9;
   localparam logic [NUM_LEGAL_OPS-1:0][6:0] LEGAL_OPS = {
      OP_REG, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
      OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL
   };

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic is_legal_op(input logic [6:0] op);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_LEGAL_OPS; i++) begin
         if (LEGAL_OPS[i] == op) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   function automatic logic is_mem_op(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with registered handshakes.
// Optional feature: ILLEGAL_OP_TRAP_EN parks the core in TRAP on an illegal opcode.
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   input  logic        dec_we,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic [63:0] pc,
   output logic        retire,
   output logic        trap
);

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        imem_req_q, imem_req_d;
   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic        rf_we_q, rf_we_d;
   logic        retire_q, retire_d;
   logic        trap_q, trap_d;

   logic [6:0]  opcode;
   logic        op_legal;

   assign opcode   = instr_q[6:0];
   assign op_legal = is_legal_op(opcode);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      imem_req_d = imem_req_q;
      dmem_req_d = dmem_req_q;
      dmem_we_d  = dmem_we_q;
      rf_we_d    = 1'b0;
      retire_d   = 1'b0;
      trap_d     = trap_q;

      case (state_q)
         ST_FETCH: begin
            // An ack is taken even before imem_req has risen, so a stale ack after reset counts.
            imem_req_d = 1'b1;
            if (imem_ack) begin
               instr_d    = imem_rdata;
               imem_req_d = 1'b0;
               state_d    = ST_DECODE;
            end
         end

         ST_DECODE: begin
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            if (!op_legal) begin
`ifdef ILLEGAL_OP_TRAP_EN
               state_d = ST_TRAP;
               trap_d  = 1'b1;
`else
               state_d  = ST_WB;
               retire_d = 1'b1;
`endif
            end else if (is_mem_op(opcode)) begin
               state_d    = ST_MEM;
               dmem_req_d = 1'b1;
               dmem_we_d  = (opcode == OP_STORE);
            end else begin
               state_d  = ST_WB;
               rf_we_d  = dec_we;
               retire_d = 1'b1;
            end
         end

         ST_MEM: begin
            if (dmem_ack) begin
               dmem_req_d = 1'b0;
               dmem_we_d  = 1'b0;
               state_d    = ST_WB;
               rf_we_d    = dec_we;
               retire_d   = 1'b1;
            end
         end

         ST_WB: begin
            if (branch_taken && op_legal) begin
               pc_d = branch_target;
            end else begin
               pc_d = pc_q + 64'd4;
            end
            imem_req_d = 1'b1;
            state_d    = ST_FETCH;
         end

         ST_TRAP: begin
            imem_req_d = 1'b0;
            dmem_req_d = 1'b0;
            dmem_we_d  = 1'b0;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_FETCH;
         pc_q       <= RESET_PC;
         instr_q    <= NOP_INSTR;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         rf_we_q    <= 1'b0;
         retire_q   <= 1'b0;
         trap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         imem_req_q <= imem_req_d;
         dmem_req_q <= dmem_req_d;
         dmem_we_q  <= dmem_we_d;
         rf_we_q    <= rf_we_d;
         retire_q   <= retire_d;
         trap_q     <= trap_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign instr     = instr_q;
   assign dmem_req  = dmem_req_q;
   assign dmem_we   = dmem_we_q;
   assign rf_we     = rf_we_q;
   assign pc        = pc_q;
   assign retire    = retire_q;
   assign trap      = trap_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed plus randomized instruction stream against a cycle-budget reference model.
module tb_exec_sequencer;

   localparam logic [63:0] RST_PC = 64'h0;
   localparam logic [31:0] W_ADDI = 32'h0010_0093;
   localparam logic [31:0] W_LD   = 32'h0000_3083;
   localparam logic [31:0] W_SD   = 32'h0010_3023;
   localparam logic [31:0] W_BEQ  = 32'h0000_0063;
   localparam logic [31:0] W_JALR = 32'h0000_0067;
   localparam logic [31:0] W_ILL  = 32'h0000_007F;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        dec_we;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        rf_we;
   logic [63:0] pc;
   logic        retire;
   logic        trap;

   int          n_tests;
   int          n_fail;
   logic [63:0] exp_pc;
   logic [6:0]  legal_ops [9];

   exec_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .dec_we(dec_we), .branch_taken(branch_taken), .branch_target(branch_target),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .pc(pc), .retire(retire), .trap(trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic model_legal(input logic [6:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one instruction from its first FETCH cycle (called at a negedge) through the pc update.
   task automatic run_instr(input string tag, input logic [31:0] word, input logic we, input logic tk,
                            input logic [63:0] tgt, input int fw, input int dw);
      logic [6:0]  op;
      logic        legal, is_mem, done, got_rfwe;
      int          cyc, mem_cnt, bad_stable, bad_excl, bad_dwe, ret_cyc;
      logic [63:0] next_pc;
      op = word[6:0];
      legal = model_legal(op);
      is_mem = legal && (op == 7'b0000011 || op == 7'b0100011);
      dec_we = we; branch_taken = tk; branch_target = tgt; imem_rdata = word;
      done = 1'b0; got_rfwe = 1'b0; cyc = 0; mem_cnt = 0;
      bad_stable = 0; bad_excl = 0; bad_dwe = 0; ret_cyc = -1;
      while (!done && cyc < 200) begin
         if (imem_req && (dmem_req || retire || rf_we)) bad_excl++;
         if (dmem_req && (retire || rf_we)) bad_excl++;
         if (pc !== exp_pc || imem_addr !== exp_pc) bad_stable++;
         if (cyc > fw && instr !== word) bad_stable++;
         if (dmem_req) begin
            mem_cnt++;
            if (dmem_we !== (op == 7'b0100011)) bad_dwe++;
         end
         if (retire) begin
            done = 1'b1; ret_cyc = cyc; got_rfwe = rf_we;
         end else begin
            imem_ack = (cyc == fw) ? 1'b1 : ((cyc > fw) ? 1'($urandom_range(0, 1)) : 1'b0);
            dmem_ack = dmem_req ? (mem_cnt == dw) : 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
         end
      end
      chk({tag, " retired"}, done, 1'b1);
      chk({tag, " latency"}, ret_cyc + 1, (fw + 1) + 3 + (is_mem ? dw : 0));
      chk({tag, " rf_we"}, got_rfwe, we & legal);
      chk({tag, " dmem_cycles"}, mem_cnt, is_mem ? dw : 0);
      chk({tag, " dmem_we"}, bad_dwe, 0);
      chk({tag, " exclusive"}, bad_excl, 0);
      chk({tag, " stable"}, bad_stable, 0);
      next_pc = (legal && tk) ? tgt : exp_pc + 64'd4;
      imem_ack = 1'b0; dmem_ack = 1'b0;
      @(negedge clk);
      chk({tag, " pc"}, pc, next_pc);
      chk({tag, " refetch"}, imem_req, 1'b1);
      chk({tag, " retire_once"}, retire, 1'b0);
      exp_pc = next_pc;
   endtask

   initial begin
      logic [6:0]  op;
      logic [31:0] word;
      int          r, hits;
      legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                    7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
      n_tests = 0; n_fail = 0; exp_pc = RST_PC;
      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; dec_we = 1'b0;
      branch_taken = 1'b0; branch_target = 64'h0; dmem_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst pc", pc, RST_PC);
      chk("rst instr", instr, 32'h0000_0013);
      chk("rst imem_req", imem_req, 1'b0);
      chk("rst dmem_req", dmem_req, 1'b0);
      chk("rst dmem_we", dmem_we, 1'b0);
      chk("rst rf_we", rf_we, 1'b0);
      chk("rst retire", retire, 1'b0);
      chk("rst trap", trap, 1'b0);
      rst_n = 1'b1;

      run_instr("addi", W_ADDI, 1'b1, 1'b0, 64'h0, 1, 0);
      run_instr("ld", W_LD, 1'b1, 1'b0, 64'h0, 2, 3);
      run_instr("sd", W_SD, 1'b0, 1'b0, 64'h0, 1, 2);
      run_instr("beq_taken", W_BEQ, 1'b0, 1'b1, 64'h100, 0, 0);
      run_instr("beq_fall", W_BEQ, 1'b0, 1'b0, 64'h200, 1, 0);
      run_instr("jalr_top", W_JALR, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
      run_instr("wrap", W_ADDI, 1'b1, 1'b0, 64'h0, 2, 0);

`ifdef ILLEGAL_OP_TRAP_EN
      imem_rdata = W_ILL; dec_we = 1'b1; branch_taken = 1'b1; branch_target = 64'h500;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("ill trap", trap, 1'b1);
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req || retire || rf_we || dmem_req || pc !== exp_pc) hits++;
         imem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      chk("ill parked", hits, 0);
      chk("ill pc", pc, exp_pc);
      imem_ack = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("ill rst trap", trap, 1'b0);
      rst_n = 1'b1;
      exp_pc = RST_PC;
`else
      run_instr("illegal", W_ILL, 1'b1, 1'b1, 64'h500, 1, 0);
      chk("illegal trap", trap, 1'b0);
`endif

      for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_OP_TRAP_EN
         r = $urandom_range(0, 8);
`else
         r = $urandom_range(0, 9);
`endif
         if (r < 9) begin
            op = legal_ops[r];
         end else begin
            do op = 7'($urandom); while (model_legal(op));
         end
         word = {$urandom} & 32'hFFFF_FF80;
         word = word | {25'h0, op};
         run_instr($sformatf("rnd%0d", n), word, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(1, 4));
      end
      chk("rnd trap", trap, 1'b0);

      imem_rdata = W_LD; dec_we = 1'b1; branch_taken = 1'b0; imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      hits = 0;
      while (!dmem_req && hits < 20) begin
         @(negedge clk);
         hits++;
      end
      chk("mid_mem reached", dmem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_mem dmem_req", dmem_req, 1'b0);
      chk("mid_mem pc", pc, RST_PC);
      chk("mid_mem imem_req", imem_req, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_pc = RST_PC;
      run_instr("stale_ack", W_ADDI, 1'b1, 1'b0, 64'h0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
